// File: rtl/sseg_pkg.sv
// Shared symbol codes, mode/message encodings and FSM state type for the
// seven-segment message driver and the per-digit decoders.
package sseg_pkg;

    localparam int SYM_W      = 5;
    localparam int NUM_DIGITS = 8;
    localparam int FRAME_W    = SYM_W * NUM_DIGITS;

    // Codes 0-15 are the hex digits themselves; letters follow.
    localparam logic [SYM_W-1:0] SYM_I   = 5'd18;
    localparam logic [SYM_W-1:0] SYM_N   = 5'd19;
    localparam logic [SYM_W-1:0] SYM_O   = 5'd20;
    localparam logic [SYM_W-1:0] SYM_P   = 5'd21;
    localparam logic [SYM_W-1:0] SYM_R   = 5'd22;
    localparam logic [SYM_W-1:0] SYM_S   = 5'd23;
    localparam logic [SYM_W-1:0] SYM_T   = 5'd24;
    localparam logic [SYM_W-1:0] SYM_U   = 5'd25;
    localparam logic [SYM_W-1:0] SYM_Y   = 5'd26;
    localparam logic [SYM_W-1:0] SYM_OFF = 5'd27;

    localparam logic [FRAME_W-1:0] FRAME_OFF = {NUM_DIGITS{SYM_OFF}};

    typedef enum logic [1:0] {
        MODE_DEC = 2'd0,
        MODE_HEX = 2'd1,
        MODE_MSG = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        MSG_RUN  = 2'd0,
        MSG_DONE = 2'd1,
        MSG_BUSY = 2'd2,
        MSG_STOP = 2'd3
    } msg_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Status words are right-aligned; digit 0 sits in the low five bits.
    function automatic logic [FRAME_W-1:0] msg_frame(input logic [1:0] sel);
        case (msg_e'(sel))
            MSG_RUN:  msg_frame = {{5{SYM_OFF}}, SYM_R, SYM_U, SYM_N};
            MSG_DONE: msg_frame = {{4{SYM_OFF}}, 5'd13, SYM_O, SYM_N, 5'd14};
            MSG_BUSY: msg_frame = {{4{SYM_OFF}}, 5'd11, SYM_U, SYM_S, SYM_Y};
            default:  msg_frame = {{4{SYM_OFF}}, SYM_S, SYM_T, SYM_O, SYM_P};
        endcase
    endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Single BCD nibble correction for shift-add-3: values of 5 or more get +3
// so the following left shift carries correctly into the next decade.
module bcd_adjust (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/sseg_msg_driver.sv
// Formats a binary value (decimal or hex) or a fixed status word into eight
// 5-bit display symbols; the visible frame only changes when a new one is done.
module sseg_msg_driver
    import sseg_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [DATA_W-1:0] value,
    input  logic [1:0]        mode,
    input  logic [1:0]        msg_sel,
    input  logic              load,
    output logic              ready,
    output logic              disp_valid,
    output logic [39:0]       digits,
    output state_e            dbg_state
);

    // Handshake: a request is taken on the rising edge where load && ready;
    // load while ready is low is dropped, and disp_valid pulses for exactly
    // one cycle (which is already an IDLE/ready cycle) after digits updates.

    localparam int HEX_DIGITS = (DATA_W + 3) / 4;
    localparam int HEX_W      = HEX_DIGITS * 4;
    localparam int SR_W       = 32 + DATA_W;

    if (DATA_W < 4 || DATA_W > 26) begin : g_bad_width
        $error("sseg_msg_driver: DATA_W must be in 4..26");
    end

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    bin_q;
    logic [31:0]          bcd_q;
    logic [31:0]          bcd_adj;
    logic [4:0]           iter_q;
    logic [1:0]           mode_q;
    logic [1:0]           msg_q;
    logic [FRAME_W-1:0]   digits_q;
    logic [FRAME_W-1:0]   frame;
    logic                 valid_q;
    logic                 conv_done;
    logic [SR_W-1:0]      shifted;
    logic [HEX_W-1:0]     hex_word;
    logic                 lead;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_adjust u_adj (
            .nib_in  (bcd_q[4*g +: 4]),
            .nib_out (bcd_adj[4*g +: 4])
        );
    end

    assign shifted   = {bcd_adj, bin_q} << 1;
    assign conv_done = (iter_q == 5'(DATA_W - 1));
    assign hex_word  = HEX_W'(bin_q);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load) state_d = (mode == MODE_DEC) ? ST_CONV : ST_FIN;
            ST_CONV: if (conv_done) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            mode_q   <= '0;
            msg_q    <= '0;
            digits_q <= FRAME_OFF;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        bin_q  <= value;
                        bcd_q  <= '0;
                        iter_q <= '0;
                        mode_q <= mode;
                        msg_q  <= msg_sel;
                    end
                end
                ST_CONV: begin
                    {bcd_q, bin_q} <= shifted;
                    iter_q         <= iter_q + 5'd1;
                end
                ST_FIN: begin
                    digits_q <= frame;
                    valid_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Decimal blanking scans from the top digit down; digit 0 always shows.
    always_comb begin
        frame = FRAME_OFF;
        lead  = 1'b1;
        case (mode_q)
            MODE_DEC: begin
                for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
                    if (lead && bcd_q[4*k +: 4] == 4'd0 && k != 0) begin
                        frame[5*k +: 5] = SYM_OFF;
                    end else begin
                        lead            = 1'b0;
                        frame[5*k +: 5] = {1'b0, bcd_q[4*k +: 4]};
                    end
                end
            end
            MODE_HEX: begin
                for (int k = 0; k < HEX_DIGITS; k++) begin
                    frame[5*k +: 5] = {1'b0, hex_word[4*k +: 4]};
                end
            end
            MODE_MSG: frame = msg_frame(msg_q);
            default:  frame = FRAME_OFF;
        endcase
    end

    assign ready      = (state_q == ST_IDLE);
    assign disp_valid = valid_q;
    assign digits     = digits_q;
    assign dbg_state  = state_q;

endmodule
